// File: rtl/ee357_right_shifter_mc.sv
// Multicycle SRL/SRA unit: shifts one bit per clock under a start/busy/done handshake,
// so the datapath needs no combinational barrel shifter.
module ee357_right_shifter_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;
  logic               mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            out  <= in;
            cnt  <= shamt;
            mode <= arith;
            if (shamt != '0) begin
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Fill comes from the current MSB, so the sign replicates across every step.
          out <= {mode & out[WIDTH-1], out[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee357_right_shifter_mc.sv
// Bench for ee357_right_shifter_mc: directed cases plus random operations checked
// against an arithmetic shift model.
module tb_ee357_right_shifter_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_d;
  logic [4:0]  shamt_d;
  logic        arith_d;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  ee357_right_shifter_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in_d),
    .shamt (shamt_d),
    .arith (arith_d),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic ar);
    if (ar) return 32'($signed(a) >>> s);
    return a >> s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // poke: pulse a junk start while shifting; b2b: hold start during the DONE cycle
  task automatic do_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                       input bit poke, input bit b2b);
    int cycles;
    int busy_cyc;
    logic [31:0] exp;
    exp = model(a, s, ar);
    @(negedge clk);
    in_d = a; shamt_d = s; arith_d = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_d = $urandom; shamt_d = 5'($urandom); arith_d = 1'($urandom);
    cycles = 0; busy_cyc = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cyc++;
      if (poke && cycles == 1) begin
        start = 1'b1; in_d = '1; shamt_d = 5'd1;
      end else start = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk("latency", 32'(cycles), 32'(s));
    chk("busy_cycles", 32'(busy_cyc), 32'(s));
    chk("result", out, exp);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    if (b2b) begin
      start = 1'b1; in_d = ~a; shamt_d = 5'd3;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("result_hold", out, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_d = '0; shamt_d = '0; arith_d = 1'b0;
    #12;
    chk("reset_out", out, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    do_op(32'h0000000C, 5'd2, 1'b0, 0, 0);
    chk("t1_value", out, 32'h00000003);
    do_op(32'hC0000000, 5'd2, 1'b0, 0, 0);
    chk("t2_srl", out, 32'h30000000);
    do_op(32'hC0000000, 5'd2, 1'b1, 0, 1);
    chk("t2_sra", out, 32'hF0000000);
    do_op(32'hDEADBEEF, 5'd0, 1'b0, 0, 1);
    chk("t3_zero", out, 32'hDEADBEEF);
    do_op(32'h80000000, 5'd31, 1'b1, 0, 0);
    chk("t4_sra31", out, 32'hFFFFFFFF);
    do_op(32'h80000000, 5'd31, 1'b0, 0, 0);
    chk("t4_srl31", out, 32'h00000001);
    do_op(32'h000000F0, 5'd4, 1'b0, 1, 0);
    chk("t5_ignored_start", out, 32'h0000000F);

    // Reset mid-shift must clear everything without waiting for an edge.
    @(negedge clk);
    in_d = 32'h12345678; shamt_d = 5'd8; arith_d = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_no_done", {30'd0, busy, done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    do_op(32'h87654321, 5'd8, 1'b1, 0, 0);
    chk("t6_after_reset", out, 32'hFF876543);

    for (int i = 0; i < 24; i++) begin
      do_op($urandom, 5'($urandom), 1'($urandom), 0, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
